// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Fixed-latency 64-bit memory responder with valid/ready request
//            and response channels, backed by a word array mapped at BASE.
//            Optional macro MEM_RESPONDER_WRAP_EN: out-of-range addresses
//            wrap modulo DEPTH (power of two) instead of returning an error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_cnt;
    logic [60:0]        r_word;
    logic               r_wen;
    logic [63:0]        r_wdata;
    logic [7:0]         r_wmask;
    logic [63:0]        r_rdata;
    logic               r_err;
    logic [63:0]        r_mem [DEPTH];

    logic               w_accept;
    logic               w_access;
    logic               w_rsp_done;
    logic [60:0]        w_word_off;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_in_range;
    logic               w_err;
    logic               w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^req_addr[2:0];

    // Decode works on word addresses; BASE is assumed to be 8-byte aligned.
    assign w_word_off = r_word - BASE[63:3];
    assign w_idx      = w_word_off[c_IDX_W-1:0];

`ifdef MEM_RESPONDER_WRAP_EN
    logic w_unused_off_hi;
    assign w_unused_off_hi = ^w_word_off[60:c_IDX_W];
    assign w_in_range      = 1'b1;
    assign w_err           = 1'b0;
`else
    assign w_in_range = (r_word >= BASE[63:3]) && (w_word_off < 61'(DEPTH));
    assign w_err      = ~w_in_range;
`endif

    assign w_accept   = req_valid && (r_state == c_ST_IDLE);
    assign w_access   = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
    assign w_rsp_done = (r_state == c_ST_RESP) && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_word  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word  <= req_addr[63:3];
                r_wen   <= req_wen;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
                r_cnt   <= c_CNT_LOAD;
            end else if ((r_state == c_ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_rdata <= (!r_wen && w_in_range) ? r_mem[w_idx] : 64'd0;
                r_err   <= w_err;
            end else if (w_rsp_done) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Array is not reset; an async reset forces IDLE so a pending write never commits.
    always_ff @(posedge clk) begin
        if (w_access && r_wen && w_in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (r_wmask[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int          n_checks;
    int          n_fail;
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        seen;

    mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request with rsp_ready held high; returns data, error and accept-to-valid edges.
    task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                          input logic [7:0] m, output logic [63:0] o_rd,
                          output logic o_er, output int o_lat);
        int k;
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        req_wmask = m;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        k = 0;
        while (!req_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_ready_wait", 64'(req_ready), 64'd0);
        o_lat = 0;
        while (!rsp_valid && o_lat < 50) begin
            @(posedge clk); #1;
            o_lat++;
        end
        o_rd = rsp_rdata;
        o_er = rsp_err;
        @(posedge clk); #1;
        check("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clk       = 1'b0;
        clk_en    = 1'b0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;

        // Asynchronous reset with the clock stopped
        #3 rst = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        check("rst_rsp_rdata", rsp_rdata,      64'd0);
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Full write then read of the same word (offset address)
        do_req(64'h8000_0008, 1'b1, 64'h1122334455667788, 8'hFF, rd, er, lat);
        check("wr_latency", 64'(lat), 64'd2);
        check("wr_rdata",   rd,       64'd0);
        check("wr_err",     64'(er),  64'd0);
        do_req(64'h8000_000C, 1'b0, 64'd0, 8'h00, rd, er, lat);
        check("rd_latency", 64'(lat), 64'd2);
        check("rd_rdata",   rd,       64'h1122334455667788);
        check("rd_err",     64'(er),  64'd0);

        // Partial write, low four bytes
        do_req(64'h8000_0008, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, er, lat);
        do_req(64'h8000_0008, 1'b0, 64'd0, 8'h00, rd, er, lat);
        check("pw_rdata", rd, 64'h11223344AAAAAAAA);

        // Backpressure: response held, second request waits for IDLE
        do_req(64'h8000_0018, 1'b1, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
        req_addr  = 64'h8000_0018;
        req_wen   = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 64'h8000_0008;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_rdata", rsp_rdata,      64'h0123456789ABCDEF);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_valid", 64'(rsp_valid), 64'd0);
        check("bp_idle_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        check("bp_second_acc", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_second_rd", rsp_rdata, 64'h11223344AAAAAAAA);
        @(posedge clk); #1;

        // Out-of-range accesses
        do_req(64'h8000_0000, 1'b1, 64'h5555555555555555, 8'hFF, rd, er, lat);
        do_req(64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, rd, er, lat);
`ifdef MEM_RESPONDER_WRAP_EN
        check("oor_rd_err", 64'(er), 64'd0);
`else
        check("oor_rd_err",   64'(er), 64'd1);
        check("oor_rd_rdata", rd,      64'd0);
`endif
        do_req(64'h8000_2000, 1'b1, 64'hFEEDFACECAFEF00D, 8'hFF, rd, er, lat);
        check("oor_wr_rdata", rd, 64'd0);
`ifdef MEM_RESPONDER_WRAP_EN
        check("oor_wr_err", 64'(er), 64'd0);
        do_req(64'h8000_0000, 1'b0, 64'd0, 8'h00, rd, er, lat);
        check("oor_mem0", rd, 64'hFEEDFACECAFEF00D);
`else
        check("oor_wr_err", 64'(er), 64'd1);
        do_req(64'h8000_0000, 1'b0, 64'd0, 8'h00, rd, er, lat);
        check("oor_mem0", rd, 64'h5555555555555555);
`endif

        // Reset while a write is counting down
        do_req(64'h8000_0010, 1'b1, 64'h0BADF00D12345678, 8'hFF, rd, er, lat);
        req_addr  = 64'h8000_0010;
        req_wen   = 1'b1;
        req_wdata = 64'hDEADBEEF00000000;
        req_wmask = 8'hFF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rw_in_wait", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rw_rst_ready", 64'(req_ready), 64'd1);
        check("rw_rst_valid", 64'(rsp_valid), 64'd0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("rw_no_rsp", 64'(seen), 64'd0);
        do_req(64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, lat);
        check("rw_prior_val", rd, 64'h0BADF00D12345678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
